// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between
// NUM_REQ byte producers. It issues one byte per frame and then tracks the
// transmitter's busy flag until the frame completes.
// Optional start-timeout watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_busy,
    output logic                          o_busy,
    output logic                          o_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             win_found;
    logic             timeout_hit;

    // Reject parameterisations the arbiter is not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    // Rotating-priority search: first pending requester at or after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!win_found && i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        o_tx_valid = 1'b0;
        o_ack      = '0;
        o_busy     = 1'b1;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (win_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                o_tx_valid = 1'b1;
                o_ack      = o_grant;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's byte and grant, advance the pointer past the winner,
    // and drop the grant whenever the frame ends.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr       <= '0;
            o_grant   <= '0;
            o_tx_data <= '0;
        end else if (state == IDLE && win_found) begin
            o_grant   <= NUM_REQ'(1) << win_idx;
            o_tx_data <= i_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
            ptr       <= (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        end else if (state != IDLE && state_nxt == IDLE) begin
            o_grant   <= '0;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt;

    // Count cycles spent waiting for the transmitter to raise busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (state == WAIT_BUSY && !i_tx_busy && !timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_hit = (state == WAIT_BUSY) && !i_tx_busy &&
                         (32'(to_cnt) == TIMEOUT_CYC - 1);
    assign o_err       = timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// The transmitter is emulated here: busy rises two cycles after valid and
// stays high for a chosen frame length. Expected grants come from a
// rotating-priority reference model over the sampled request vector.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    o_ack;
    logic [N-1:0]    o_grant;
    logic [DW-1:0]   o_tx_data;
    logic            o_tx_valid;
    logic            i_tx_busy;
    logic            o_busy;
    logic            o_err;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_data    (i_data),
        .o_ack     (o_ack),
        .o_grant   (o_grant),
        .o_tx_data (o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_tx_busy (i_tx_busy),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Reference: walk the requesters in order starting at p, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] byte_of(input int k);
        if (k < 0) return '0;
        return i_data[k*DW +: DW];
    endfunction

    // Advance cycles until o_tx_valid is seen; cyc = cycles waited, -1 on expiry.
    task automatic wait_issue(input int max_cyc, output int cyc);
        int k;
        cyc = -1;
        k   = 0;
        while (cyc < 0 && k < max_cyc) begin
            k++;
            @(posedge i_clk); #1;
            @(negedge i_clk);
            if (o_tx_valid === 1'b1) cyc = k;
        end
    endtask

    // Emulate the transmitter for one frame after issue and record observations.
    task automatic serve_frame(input int len, input logic [N-1:0] mid_req, input bit mid_en,
                               output int bad_busy, output int stray, output int unstable,
                               output logic [N-1:0] idle_grant);
        logic [DW-1:0] held_d;
        logic [N-1:0]  held_g;
        held_d   = o_tx_data;
        held_g   = o_grant;
        bad_busy = 0;
        stray    = 0;
        unstable = 0;
        idle_grant = 'x;
        for (int t = 1; t <= len + 3; t++) begin
            @(posedge i_clk); #1;
            i_tx_busy = (t >= 2 && t <= len + 1);
            if (mid_en && t == 3) i_req = mid_req;
            @(negedge i_clk);
            if (o_busy !== (t <= len + 2)) bad_busy++;
            if (o_tx_valid !== 1'b0 || o_ack !== '0) stray++;
            if (t <= len + 2 && (o_tx_data !== held_d || o_grant !== held_g)) unstable++;
            if (t == len + 3) idle_grant = o_grant;
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        n_tests++; if (o_grant !== '0 || o_ack !== '0) begin n_fail++; $display("FAIL reset_grant_ack: grant=%b ack=%b want 0", o_grant, o_ack); end
        n_tests++; if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: valid=%b busy=%b err=%b want 0", o_tx_valid, o_busy, o_err); end
        n_tests++; if (o_tx_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_tx_data); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_single();
        int cyc, pick, bb, st, un;
        logic [N-1:0] ig;
        i_data = {8'($urandom), 8'hA5, 8'($urandom), 8'($urandom)};
        i_req  = 4'b0100;
        wait_issue(6, cyc);
        pick = rr_pick(i_req, ptr_m);
        n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", cyc); end
        n_tests++; if (o_tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", o_tx_data); end
        n_tests++; if (o_ack !== onehot(pick) || o_grant !== onehot(pick)) begin n_fail++; $display("FAIL single_ack: ack=%b grant=%b want %b", o_ack, o_grant, onehot(pick)); end
        ptr_m = (pick + 1) % N;
        i_req = '0;
        serve_frame(4, '0, 1'b0, bb, st, un, ig);
        n_tests++; if (bb !== 0) begin n_fail++; $display("FAIL single_busy_track: %0d bad cycles want 0", bb); end
        n_tests++; if (st !== 0 || un !== 0 || ig !== '0) begin n_fail++; $display("FAIL single_frame: stray=%0d unstable=%0d idle_grant=%b want 0/0/0000", st, un, ig); end
    endtask

    // Starts with the pointer at 3: 0011 must pick 0, then 1, then 0 again.
    task automatic test_wrap_skip();
        int cyc, pick, bb, st, un;
        logic [N-1:0] ig;
        logic [N-1:0] seq [3];
        seq[0] = 4'b0011;
        seq[1] = 4'b0010;
        seq[2] = 4'b0001;
        n_tests++; if (ptr_m !== 3) begin n_fail++; $display("FAIL wrap_setup: model ptr %0d want 3", ptr_m); end
        for (int f = 0; f < 3; f++) begin
            i_data = $urandom;
            i_req  = seq[f];
            wait_issue(6, cyc);
            pick = rr_pick(i_req, ptr_m);
            n_tests++; if (cyc !== 1 || o_grant !== onehot(pick) || o_tx_data !== byte_of(pick)) begin n_fail++; $display("FAIL wrap_grant%0d: cyc=%0d grant=%b data=%h want 1/%b/%h", f, cyc, o_grant, o_tx_data, onehot(pick), byte_of(pick)); end
            ptr_m = (pick + 1) % N;
            i_req[pick] = 1'b0;
            serve_frame($urandom_range(1, 5), '0, 1'b0, bb, st, un, ig);
            n_tests++; if (bb + st + un !== 0) begin n_fail++; $display("FAIL wrap_frame%0d: busy=%0d stray=%0d unstable=%0d want 0", f, bb, st, un); end
        end
        i_req = '0;
    endtask

    task automatic test_round_robin();
        int cyc, pick, prev, bb, st, un;
        logic [N-1:0] ig;
        i_data = $urandom;
        i_req  = '1;
        prev   = -1;
        for (int f = 0; f < 8; f++) begin
            wait_issue(6, cyc);
            pick = rr_pick(i_req, ptr_m);
            n_tests++; if (cyc !== 1 || o_ack !== onehot(pick) || o_grant !== onehot(pick)) begin n_fail++; $display("FAIL rr_grant%0d: cyc=%0d ack=%b grant=%b want 1/%b", f, cyc, o_ack, o_grant, onehot(pick)); end
            n_tests++; if (o_tx_data !== byte_of(pick)) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", f, o_tx_data, byte_of(pick)); end
            if (prev >= 0) begin
                n_tests++; if (!$onehot(o_grant) || o_grant !== onehot((prev + 1) % N)) begin n_fail++; $display("FAIL rr_rotate%0d: grant=%b want %b", f, o_grant, onehot((prev + 1) % N)); end
            end
            prev  = pick;
            ptr_m = (pick + 1) % N;
            i_data[pick*DW +: DW] = 8'($urandom);
            serve_frame($urandom_range(1, 6), '0, 1'b0, bb, st, un, ig);
            n_tests++; if (bb + st + un !== 0 || ig !== '0) begin n_fail++; $display("FAIL rr_frame%0d: busy=%0d stray=%0d unstable=%0d idle_grant=%b want 0", f, bb, st, un, ig); end
        end
        i_req = '0;
    endtask

    task automatic test_req_during_frame();
        int cyc, pick, bb, st, un;
        logic [N-1:0] ig;
        i_data = $urandom;
        i_req  = 4'b0001;
        wait_issue(6, cyc);
        pick  = rr_pick(i_req, ptr_m);
        ptr_m = (pick + 1) % N;
        i_req = '0;
        serve_frame(5, 4'b0010, 1'b1, bb, st, un, ig);
        n_tests++; if (st !== 0 || bb !== 0) begin n_fail++; $display("FAIL during_no_ack: stray=%0d busy=%0d want 0", st, bb); end
        wait_issue(6, cyc);
        pick = rr_pick(i_req, ptr_m);
        n_tests++; if (cyc !== 1 || o_ack !== 4'b0010 || o_ack !== onehot(pick)) begin n_fail++; $display("FAIL during_issue: cyc=%0d ack=%b want 1/0010", cyc, o_ack); end
        ptr_m = (pick + 1) % N;
        i_req = '0;
        serve_frame(2, '0, 1'b0, bb, st, un, ig);
    endtask

    task automatic test_timeout();
        int cyc, pick, bad, bb, st, un;
        logic [N-1:0] ig;
        i_data = $urandom;
        i_req  = 4'b1000;
        wait_issue(6, cyc);
        pick  = rr_pick(i_req, ptr_m);
        ptr_m = (pick + 1) % N;
        i_req = '0;
        bad   = 0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int t = 1; t <= TO + 1; t++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            if (o_err !== (t == TO)) bad++;
            if (o_busy !== (t <= TO)) bad++;
        end
        n_tests++; if (bad !== 0 || o_grant !== '0) begin n_fail++; $display("FAIL timeout_err: %0d bad cycles grant=%b want 0", bad, o_grant); end
`else
        for (int t = 1; t <= 20; t++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            if (o_err !== 1'b0 || o_busy !== 1'b1) bad++;
        end
        n_tests++; if (bad !== 0 || o_grant !== onehot(pick)) begin n_fail++; $display("FAIL timeout_hold: %0d bad cycles grant=%b want %b", bad, o_grant, onehot(pick)); end
        serve_frame(3, '0, 1'b0, bb, st, un, ig);
        n_tests++; if (bb + st + un !== 0 || ig !== '0) begin n_fail++; $display("FAIL timeout_late_frame: busy=%0d stray=%0d unstable=%0d want 0", bb, st, un); end
`endif
        i_req = 4'b0001;
        wait_issue(6, cyc);
        pick = rr_pick(i_req, ptr_m);
        n_tests++; if (cyc !== 1 || o_grant !== onehot(pick)) begin n_fail++; $display("FAIL timeout_recover: cyc=%0d grant=%b want 1/%b", cyc, o_grant, onehot(pick)); end
        ptr_m = (pick + 1) % N;
        i_req = '0;
        serve_frame(2, '0, 1'b0, bb, st, un, ig);
    endtask

    task automatic test_reset_midframe();
        int cyc, pick, bb, st, un;
        logic [N-1:0] ig;
        i_data = $urandom;
        i_req  = 4'b0100;
        wait_issue(6, cyc);
        i_req = '0;
        for (int t = 1; t <= 3; t++) begin
            @(posedge i_clk); #1;
            i_tx_busy = (t >= 2);
            if (t == 3) begin
                #1;
                n_tests++; if (o_busy !== 1'b1 || o_grant !== 4'b0100) begin n_fail++; $display("FAIL midrst_pre: busy=%b grant=%b want 1/0100", o_busy, o_grant); end
                #1 i_rst = 1'b1;
                #1;
                n_tests++; if (o_busy !== 1'b0 || o_grant !== '0 || o_ack !== '0 || o_tx_valid !== 1'b0 || o_err !== 1'b0 || o_tx_data !== '0) begin n_fail++; $display("FAIL midrst_outputs: busy=%b grant=%b ack=%b valid=%b err=%b data=%h want all 0", o_busy, o_grant, o_ack, o_tx_valid, o_err, o_tx_data); end
            end
        end
        @(posedge i_clk); #1;
        i_tx_busy = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        ptr_m = 0;
        @(negedge i_clk);
        i_data = $urandom;
        i_req  = '1;
        wait_issue(6, cyc);
        pick = rr_pick(i_req, ptr_m);
        n_tests++; if (cyc !== 1 || o_grant !== 4'b0001 || o_grant !== onehot(pick) || o_tx_data !== byte_of(pick)) begin n_fail++; $display("FAIL midrst_after: cyc=%0d grant=%b data=%h want 1/0001/%h", cyc, o_grant, o_tx_data, byte_of(pick)); end
        ptr_m = (pick + 1) % N;
        i_req = '0;
        serve_frame(3, '0, 1'b0, bb, st, un, ig);
    endtask

    task automatic test_random();
        int cyc, pick, bb, st, un, len;
        logic [N-1:0] ig, mid;
        bit men;
        i_data = $urandom;
        i_req  = 4'b0001 | 4'($urandom);
        for (int f = 0; f < 24; f++) begin
            wait_issue(6, cyc);
            pick = rr_pick(i_req, ptr_m);
            n_tests++; if (cyc !== 1 || o_ack !== onehot(pick) || o_grant !== onehot(pick)) begin n_fail++; $display("FAIL rand_grant%0d: cyc=%0d ack=%b grant=%b want 1/%b", f, cyc, o_ack, o_grant, onehot(pick)); end
            n_tests++; if (o_tx_data !== byte_of(pick)) begin n_fail++; $display("FAIL rand_data%0d: got %h want %h", f, o_tx_data, byte_of(pick)); end
            ptr_m = (pick + 1) % N;
            if (pick >= 0) i_req[pick] = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!i_req[k]) i_data[k*DW +: DW] = 8'($urandom);
            end
            i_req = i_req | (4'($urandom) & 4'($urandom));
            men   = 1'($urandom);
            mid   = i_req | 4'($urandom);
            if (i_req == '0 && !men) i_req[$urandom_range(0, N-1)] = 1'b1;
            len = $urandom_range(1, 6);
            serve_frame(len, mid, men, bb, st, un, ig);
            n_tests++; if (bb + st + un !== 0 || ig !== '0) begin n_fail++; $display("FAIL rand_frame%0d: busy=%0d stray=%0d unstable=%0d idle_grant=%b want 0", f, bb, st, un, ig); end
        end
        i_req = '0;
    endtask

    initial begin
        i_rst     = 1'b1;
        i_req     = '0;
        i_data    = '0;
        i_tx_busy = 1'b0;
        test_reset();
        test_single();
        test_wrap_skip();
        test_round_robin();
        test_req_during_frame();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
